// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction width and
// the default reset PC / bubble instruction used by the fetch block.
package instruction_fetch_pkg;

   localparam int unsigned INSN_W = 32;

   localparam logic [INSN_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSN_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

   // RUN: a fetch request is outstanding.
   // BUF: one fetched word is parked in the skid buffer and fetch is paused.
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_BUF = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory port of the fetch stage.
//
// Handshake: the fetch side raises imem_req with a word-aligned imem_addr;
// the memory side answers by raising imem_ready in a cycle where imem_req=1,
// with imem_rdata carrying the word for that imem_addr. A response is
// accepted on the rising edge where imem_req && imem_ready; imem_ready is
// ignored whenever imem_req is low.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word (and its PC) that arrived
// while decode was stalled. Clear wins over load.
module fetch_skid_buffer
   import instruction_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [INSN_W-1:0] pc_i,
   input  logic [INSN_W-1:0] word_i,
   output logic              valid_o,
   output logic [INSN_W-1:0] pc_o,
   output logic [INSN_W-1:0] word_o
);

   logic              valid_q;
   logic [INSN_W-1:0] pc_q;
   logic [INSN_W-1:0] word_q;

   // Park a word on load, drop it on clear or reset.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         word_q  <= NOP_INSN_DEFAULT;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         word_q  <= word_i;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign word_o  = word_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/BUF fetch FSM, IF/ID pipeline
// register and a one-entry skid buffer that catches a response arriving
// while decode is stalled, so no accepted word is lost or duplicated.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [INSN_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   instruction_fetch_if.master  imem,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [INSN_W-1:0]    redirect_pc,
   output logic                 if_valid,
   output logic [INSN_W-1:0]    if_pc,
   output logic [INSN_W-1:0]    if_instruction,
   output fetch_state_e         dbg_state_o
);

   fetch_state_e      state_q, state_d;
   logic [INSN_W-1:0] pc_q, pc_d;
   logic              if_valid_q, if_valid_d;
   logic [INSN_W-1:0] if_pc_q, if_pc_d;
   logic [INSN_W-1:0] if_insn_q, if_insn_d;

   logic              skid_load, skid_clear;
   logic              skid_valid;
   logic [INSN_W-1:0] skid_pc, skid_word;

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear_i (skid_clear),
      .load_i  (skid_load),
      .pc_i    (pc_q),
      .word_i  (imem.imem_rdata),
      .valid_o (skid_valid),
      .pc_o    (skid_pc),
      .word_o  (skid_word)
   );

   // State, PC and IF/ID registers; reset overrides flush and stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= {RESET_PC[INSN_W-1:2], 2'b00};
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_insn_q  <= NOP_INSN;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_insn_q  <= if_insn_d;
      end
   end

   // Next-state logic: flush first, then the RUN/BUF stall handling.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_insn_d  = if_insn_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (flush) begin
         // Redirect drops the parked word and any same-cycle response.
         state_d    = ST_RUN;
         pc_d       = redirect_pc & ~32'h0000_0003;
         if_valid_d = 1'b0;
         if_insn_d  = NOP_INSN;
         skid_clear = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (imem.imem_ready && !stall) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_insn_d  = imem.imem_rdata;
                  pc_d       = pc_q + 32'd4;
               end else if (imem.imem_ready && stall) begin
                  // Decode is busy: park the word, stop requesting.
                  skid_load  = 1'b1;
                  pc_d       = pc_q + 32'd4;
                  state_d    = ST_BUF;
               end else if (!stall) begin
                  // No response and decode free: insert a bubble.
                  if_valid_d = 1'b0;
                  if_insn_d  = NOP_INSN;
               end
            end
            ST_BUF: begin
               if (!stall) begin
                  if_valid_d = skid_valid;
                  if_pc_d    = skid_pc;
                  if_insn_d  = skid_word;
                  skid_clear = 1'b1;
                  state_d    = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign imem.imem_req   = (state_q == ST_RUN);
   assign imem.imem_addr  = pc_q;
   assign if_valid        = if_valid_q;
   assign if_pc           = if_pc_q;
   assign if_instruction  = if_insn_q;
   assign dbg_state_o     = state_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset, bits [1:0] SHALL be zero.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013: instruction word presented when no valid instruction is held.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, equal to the internal PC.
REQ-007 imem_ready  input  1  imem_rdata valid for imem_addr this cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  decode stage cannot accept; IF/ID contents SHALL hold.
REQ-010 flush  input  1  redirect request from branch resolution.
REQ-011 redirect_pc  input  32  new PC, sampled when flush=1.
REQ-012 if_valid  output  1  IF/ID register holds a live instruction.
REQ-013 if_pc  output  32  PC of the held instruction.
REQ-014 if_instruction  output  32  held instruction word, driven to decode/immediate generation.

Function
REQ-015 The block SHALL have two states: RUN (request outstanding) and BUF (one fetched word parked in the skid buffer).
REQ-016 In RUN, imem_req SHALL be 1; in BUF, imem_req SHALL be 0; imem_addr SHALL always equal PC.
REQ-017 RUN, imem_ready=1, stall=0: IF/ID SHALL load {1, PC, imem_rdata} and PC SHALL become PC+4; one-cycle fetch-to-IF/ID latency.
REQ-018 RUN, imem_ready=1, stall=1: the word and PC SHALL be written to the skid buffer, PC SHALL become PC+4, state SHALL go to BUF, and IF/ID SHALL hold.
REQ-019 RUN, imem_ready=0, stall=0: if_valid SHALL become 0 (bubble), if_instruction SHALL become NOP_INSN, and PC SHALL hold.
REQ-020 RUN, imem_ready=0, stall=1: all state SHALL hold.
REQ-021 BUF, stall=1: all state SHALL hold; BUF, stall=0: IF/ID SHALL load the buffer contents with valid=1 and state SHALL return to RUN.
REQ-022 flush=1 SHALL take priority over stall and imem_ready: PC SHALL take {redirect_pc[31:2],2'b00}, the skid buffer SHALL be discarded, state SHALL become RUN, if_valid SHALL become 0, if_instruction SHALL become NOP_INSN, and any same-cycle memory response SHALL be dropped.
REQ-023 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-024 The block SHALL never lose or duplicate an instruction between flushes: every accepted imem response SHALL reach IF/ID exactly once, in address order.

Reset
REQ-025 rst=1 SHALL set PC=RESET_PC, state=RUN, if_valid=0, if_pc=0, if_instruction=NOP_INSN, and clear the skid buffer; rst SHALL override flush and stall.
REQ-026 The first cycle after reset release SHALL show imem_req=1, imem_addr=RESET_PC.
REQ-027 Reset asserted mid-operation (including in BUF) SHALL discard all held and parked instructions.

Structure
REQ-028 A shared pipeline package SHALL hold the fetch state enum, NOP_INSN, the default RESET_PC, and the instruction width constant (32).
REQ-029 The skid buffer SHALL be a sub-module, fetch_skid_buffer (one entry: valid, pc, word), instantiated once; the IF/ID register and FSM SHALL reside in instruction_fetch.

Verification
REQ-030 Reset then imem_ready=1 continuously with stall=0: imem_addr sequence 0,4,8,C; if_pc lags by one cycle with if_valid=1.
REQ-031 stall=1 for 3 cycles coinciding with the response for PC=8 (word 32'h00A0_0093): state=BUF, imem_req=0, IF/ID holds PC=4; after stall drops, if_pc=8 with that word, and fetch resumes at C.
REQ-032 flush with redirect_pc=32'h0000_0103 while in BUF: next imem_addr=32'h0000_0100, if_valid=0, and the parked word never appears on if_instruction.
REQ-033 imem_ready low for 2 cycles at PC=10: two bubbles (if_valid=0, if_instruction=NOP_INSN); PC stays 10 until ready.
REQ-034 PC=32'hFFFF_FFFC with ready: next imem_addr=0. Assert rst in BUF: outputs return to REQ-025 values on the next edge.
